// File: rtl/cl_pkg.sv
// Shared definitions for the cl_frame_tx synthetic Camera Link frame source.
package cl_pkg;

  localparam int CL_ADDR_WIDTH  = 11;
  localparam int CL_PIXEL_WIDTH = 8;

  typedef enum logic [1:0] {
    PAT_HRAMP = 2'd0,
    PAT_VRAMP = 2'd1,
    PAT_SPOT  = 2'd2,
    PAT_CHECK = 2'd3
  } cl_pat_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEAD   = 3'd1,
    ST_ACTIVE = 3'd2,
    ST_HBLANK = 3'd3,
    ST_VBLANK = 3'd4
  } cl_state_e;

endpackage

// File: rtl/cl_pixel_src.sv
// Combinational pattern generator: maps one (x,y) coordinate and the latched
// frame configuration to a pixel value.
module cl_pixel_src
  import cl_pkg::*;
#(
  parameter int ADDR_WIDTH  = CL_ADDR_WIDTH,
  parameter int PIXEL_WIDTH = CL_PIXEL_WIDTH
) (
  input  logic [ADDR_WIDTH-1:0]  i_x,
  input  logic [ADDR_WIDTH-1:0]  i_y,
  input  cl_pat_e                i_pattern,
  input  logic [ADDR_WIDTH-1:0]  i_spot_x,
  input  logic [ADDR_WIDTH-1:0]  i_spot_y,
  input  logic [ADDR_WIDTH-1:0]  i_spot_r,
  input  logic [PIXEL_WIDTH-1:0] i_fg,
  input  logic [PIXEL_WIDTH-1:0] i_bg,
  output logic [PIXEL_WIDTH-1:0] o_pixel
);

  localparam int AW = ADDR_WIDTH;

  logic [AW:0]     w_dx, w_dy;
  logic [2*AW+1:0] w_dx_ext, w_dy_ext, w_dx2, w_dy2;
  logic [2*AW+2:0] w_d2;
  logic [2*AW-1:0] w_r_ext, w_r2;
  logic            w_in_spot;

  // Two's-complement differences, sign-extended so the truncated unsigned
  // square equals the true (non-negative) square.
  assign w_dx     = {1'b0, i_x} - {1'b0, i_spot_x};
  assign w_dy     = {1'b0, i_y} - {1'b0, i_spot_y};
  assign w_dx_ext = {{(AW+1){w_dx[AW]}}, w_dx};
  assign w_dy_ext = {{(AW+1){w_dy[AW]}}, w_dy};
  assign w_dx2    = w_dx_ext * w_dx_ext;
  assign w_dy2    = w_dy_ext * w_dy_ext;
  assign w_d2     = {1'b0, w_dx2} + {1'b0, w_dy2};
  assign w_r_ext  = {{AW{1'b0}}, i_spot_r};
  assign w_r2     = w_r_ext * w_r_ext;
  assign w_in_spot = (w_d2 <= {3'b000, w_r2});

  always_comb begin
    o_pixel = i_bg;
    case (i_pattern)
      PAT_HRAMP: o_pixel = i_x[PIXEL_WIDTH-1:0];
      PAT_VRAMP: o_pixel = i_y[PIXEL_WIDTH-1:0];
      PAT_SPOT:  o_pixel = w_in_spot ? i_fg : i_bg;
      PAT_CHECK: o_pixel = (i_x[3] ^ i_y[3]) ? i_fg : i_bg;
      default:   o_pixel = i_bg;
    endcase
  end

endmodule

// File: rtl/cl_frame_tx.sv
// Camera Link-style frame source: VSYNC/HSYNC/DE timing plus two pixels per clock.
// Optional CL_TX_NOISE_EN adds LFSR dither to the two LSBs of each pixel.
module cl_frame_tx
  import cl_pkg::*;
#(
  parameter int ADDR_WIDTH  = CL_ADDR_WIDTH,
  parameter int PIXEL_WIDTH = CL_PIXEL_WIDTH,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int H_BLANK     = 64,
  parameter int V_BLANK     = 8
) (
  input  logic                   CCLK,
  input  logic                   RST_N,
  input  logic                   iENABLE,
  input  logic [1:0]             iPATTERN,
  input  logic [ADDR_WIDTH-1:0]  iSPOT_X,
  input  logic [ADDR_WIDTH-1:0]  iSPOT_Y,
  input  logic [ADDR_WIDTH-1:0]  iSPOT_R,
  input  logic [PIXEL_WIDTH-1:0] iFG_LEVEL,
  input  logic [PIXEL_WIDTH-1:0] iBG_LEVEL,
  output logic                   oVSYNC,
  output logic                   oHSYNC,
  output logic                   oDE,
  output logic [PIXEL_WIDTH-1:0] oDATA_L,
  output logic [PIXEL_WIDTH-1:0] oDATA_R,
  output logic [15:0]            oFRAME_CNT,
  output logic                   oBUSY
);

  localparam int HALF    = H_ACTIVE / 2;
  localparam int VB_CLKS = V_BLANK * (HALF + H_BLANK);
  localparam int VB_W    = $clog2(VB_CLKS + 1);
  localparam int CNT_W   = (VB_W > ADDR_WIDTH) ? VB_W : ADDR_WIDTH;

  localparam logic [CNT_W-1:0]      L_HB_LAST  = CNT_W'(H_BLANK - 1);
  localparam logic [CNT_W-1:0]      L_HA_LAST  = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0]      L_VB_LAST  = CNT_W'(VB_CLKS - 1);
  localparam logic [ADDR_WIDTH-1:0] L_ROW_LAST = ADDR_WIDTH'(V_ACTIVE - 1);

  cl_state_e             r_state, w_state_next;
  logic [CNT_W-1:0]      r_cnt, w_cnt_next;
  logic [ADDR_WIDTH-1:0] r_row, w_row_next;
  logic                  w_latch, w_frame_inc;

  cl_pat_e               r_pattern;
  logic [ADDR_WIDTH-1:0] r_spot_x, r_spot_y, r_spot_r;
  logic [PIXEL_WIDTH-1:0] r_fg, r_bg;

  logic                   r_vsync, r_de, r_busy;
  logic [PIXEL_WIDTH-1:0] r_data_l, r_data_r;
  logic [15:0]            r_frame;
  logic [PIXEL_WIDTH-1:0] w_pix   [2];
  logic [PIXEL_WIDTH-1:0] w_noise [2];

  always_ff @(posedge CCLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_row   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_row   <= w_row_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt + 1'b1;
    w_row_next   = r_row;
    w_latch      = 1'b0;
    w_frame_inc  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_next = '0;
        if (iENABLE) begin
          w_state_next = ST_LEAD;
          w_latch      = 1'b1;
        end
      end
      ST_LEAD: begin
        if (r_cnt == L_HB_LAST) begin
          w_state_next = ST_ACTIVE;
          w_cnt_next   = '0;
          w_row_next   = '0;
        end
      end
      ST_ACTIVE: begin
        if (r_cnt == L_HA_LAST) begin
          w_state_next = ST_HBLANK;
          w_cnt_next   = '0;
        end
      end
      ST_HBLANK: begin
        if (r_cnt == L_HB_LAST) begin
          w_cnt_next = '0;
          if (r_row == L_ROW_LAST) begin
            w_state_next = ST_VBLANK;
            w_frame_inc  = 1'b1;
          end else begin
            w_state_next = ST_ACTIVE;
            w_row_next   = r_row + 1'b1;
          end
        end
      end
      ST_VBLANK: begin
        if (r_cnt == L_VB_LAST) begin
          w_cnt_next = '0;
          if (iENABLE) begin
            w_state_next = ST_LEAD;
            w_latch      = 1'b1;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Shadow config only changes on frame start, so a frame is always self-consistent.
  always_ff @(posedge CCLK or negedge RST_N) begin
    if (!RST_N) begin
      r_pattern <= PAT_HRAMP;
      r_spot_x  <= '0;
      r_spot_y  <= '0;
      r_spot_r  <= '0;
      r_fg      <= '0;
      r_bg      <= '0;
    end else if (w_latch) begin
      r_pattern <= cl_pat_e'(iPATTERN);
      r_spot_x  <= iSPOT_X;
      r_spot_y  <= iSPOT_Y;
      r_spot_r  <= iSPOT_R;
      r_fg      <= iFG_LEVEL;
      r_bg      <= iBG_LEVEL;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_pix
      cl_pixel_src #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .PIXEL_WIDTH (PIXEL_WIDTH)
      ) u_src (
        .i_x       ({r_cnt[ADDR_WIDTH-2:0], 1'(gi)}),
        .i_y       (r_row),
        .i_pattern (r_pattern),
        .i_spot_x  (r_spot_x),
        .i_spot_y  (r_spot_y),
        .i_spot_r  (r_spot_r),
        .i_fg      (r_fg),
        .i_bg      (r_bg),
        .o_pixel   (w_pix[gi])
      );
    end
  endgenerate

`ifdef CL_TX_NOISE_EN
  logic [15:0] r_lfsr;

  always_ff @(posedge CCLK or negedge RST_N) begin
    if (!RST_N) begin
      r_lfsr <= 16'hACE1;
    end else if (r_state == ST_ACTIVE) begin
      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
  end

  assign w_noise[0] = {{(PIXEL_WIDTH-2){1'b0}}, r_lfsr[1:0]};
  assign w_noise[1] = {{(PIXEL_WIDTH-2){1'b0}}, r_lfsr[3:2]};
`else
  assign w_noise[0] = '0;
  assign w_noise[1] = '0;
`endif

  always_ff @(posedge CCLK or negedge RST_N) begin
    if (!RST_N) begin
      r_vsync  <= 1'b0;
      r_de     <= 1'b0;
      r_busy   <= 1'b0;
      r_data_l <= '0;
      r_data_r <= '0;
      r_frame  <= '0;
    end else begin
      r_vsync  <= (r_state == ST_LEAD) || (r_state == ST_ACTIVE) || (r_state == ST_HBLANK);
      r_de     <= (r_state == ST_ACTIVE);
      r_busy   <= (r_state != ST_IDLE);
      r_data_l <= (r_state == ST_ACTIVE) ? (w_pix[0] ^ w_noise[0]) : '0;
      r_data_r <= (r_state == ST_ACTIVE) ? (w_pix[1] ^ w_noise[1]) : '0;
      if (w_frame_inc) r_frame <= r_frame + 16'd1;
    end
  end

  assign oVSYNC     = r_vsync;
  assign oHSYNC     = r_de;
  assign oDE        = r_de;
  assign oDATA_L    = r_data_l;
  assign oDATA_R    = r_data_r;
  assign oFRAME_CNT = r_frame;
  assign oBUSY      = r_busy;

endmodule
